// File: rtl/key_tracker.sv
// Stage-1 key/door progress tracker: keys must be collected in order, then the door
// clears the stage. All outputs are registered; tracking is live only in STAGE1.
module key_tracker #(
    parameter int unsigned COOLDOWN = 25_000_000,
    parameter logic [3:0]  STAGE1   = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    input  logic       act,
    output logic [1:0] key_find,
    output logic       pick_pulse,
    output logic       stage_clear,
    output logic       busy
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_COOL,
        S_DOOR,
        S_CLEAR
    } fsm_t;

    fsm_t          fsm, fsm_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    key_nxt;
    logic          pick_nxt, clear_nxt, busy_nxt;
    logic          in_key, in_door;

    // 20x20 hit box; subtracting only after the lower-bound test avoids wrap-around.
    function automatic logic in_box(input logic [8:0] x, input logic [8:0] y,
                                    input logic [8:0] x0, input logic [8:0] y0);
        return (x >= x0) && ((x - x0) < 9'd20) && (y >= y0) && ((y - y0) < 9'd20);
    endfunction

    always_comb begin
        in_key = 1'b0;
        case (key_find)
            2'd0:    in_key = in_box(player_x, player_y, 9'd65,  9'd35);
            2'd1:    in_key = in_box(player_x, player_y, 9'd235, 9'd35);
            default: in_key = in_box(player_x, player_y, 9'd235, 9'd205);
        endcase
        in_door = in_box(player_x, player_y, 9'd145, 9'd0);
    end

    // Leaving STAGE1 overrides everything, including a same-cycle act.
    always_comb begin
        fsm_nxt   = fsm;
        key_nxt   = key_find;
        cnt_nxt   = cnt;
        pick_nxt  = 1'b0;
        clear_nxt = 1'b0;
        if (state != STAGE1) begin
            fsm_nxt = S_IDLE;
            key_nxt = 2'd0;
            cnt_nxt = '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    fsm_nxt = S_HUNT;
                    key_nxt = 2'd0;
                    cnt_nxt = '0;
                end
                S_HUNT: begin
                    if (act && in_key) begin
                        key_nxt  = key_find + 2'd1;
                        pick_nxt = 1'b1;
                        cnt_nxt  = CNT_LOAD;
                        fsm_nxt  = S_COOL;
                    end
                end
                S_COOL: begin
                    if (cnt == '0)
                        fsm_nxt = (key_find == 2'd3) ? S_DOOR : S_HUNT;
                    else
                        cnt_nxt = cnt - 1'b1;
                end
                S_DOOR: begin
                    if (act && in_door) begin
                        clear_nxt = 1'b1;
                        fsm_nxt   = S_CLEAR;
                    end
                end
                S_CLEAR: ;
                default: begin
                    fsm_nxt = S_IDLE;
                    key_nxt = 2'd0;
                    cnt_nxt = '0;
                end
            endcase
        end
        busy_nxt = (fsm_nxt == S_COOL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            cnt         <= '0;
            key_find    <= 2'd0;
            pick_pulse  <= 1'b0;
            stage_clear <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fsm         <= fsm_nxt;
            cnt         <= cnt_nxt;
            key_find    <= key_nxt;
            pick_pulse  <= pick_nxt;
            stage_clear <= clear_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_key_tracker.sv
// Directed-vector bench for key_tracker with COOLDOWN=4: a table walks a full stage,
// then hand-written sequences cover hit-box edges, async reset and aborts.
module tb_key_tracker;

    logic       clk;
    logic       rst_n;
    logic [3:0] state;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic       act;
    logic [1:0] key_find;
    logic       pick_pulse;
    logic       stage_clear;
    logic       busy;

    int checks_total;
    int checks_passed;

    key_tracker #(
        .COOLDOWN(4),
        .STAGE1  (4'd2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .player_x   (player_x),
        .player_y   (player_y),
        .act        (act),
        .key_find   (key_find),
        .pick_pulse (pick_pulse),
        .stage_clear(stage_clear),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [8:0] x;
        logic [8:0] y;
        logic       a;
        logic [1:0] kf;
        logic       pp;
        logic       sc;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] st, input int x, input int y, input logic a,
                           input logic [1:0] kf, input logic pp, input logic sc,
                           input logic bz);
        vec_t v;
        v.st = st; v.x = 9'(x); v.y = 9'(y); v.a = a;
        v.kf = kf; v.pp = pp; v.sc = sc; v.bz = bz;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and let one active edge consume them.
    task automatic apply_stimulus(input logic [3:0] st, input int x, input int y,
                                  input logic a);
        state    = st;
        player_x = 9'(x);
        player_y = 9'(y);
        act      = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [1:0] kf, input logic pp,
                                input logic sc, input logic bz);
        checks_total++;
        if (key_find === kf && pick_pulse === pp && stage_clear === sc && busy === bz)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got key_find=%0d pick=%b clear=%b busy=%b, want key_find=%0d pick=%b clear=%b busy=%b",
                     name, key_find, pick_pulse, stage_clear, busy, kf, pp, sc, bz);
    endtask

    task automatic step_check(input string name, input logic [3:0] st, input int x,
                              input int y, input logic a, input logic [1:0] kf,
                              input logic pp, input logic sc, input logic bz);
        apply_stimulus(st, x, y, a);
        check_output(name, kf, pp, sc, bz);
    endtask

    // Three more busy cycles after the pickup edge, then back to idle-busy.
    task automatic cooldown_tail(input string name, input logic [1:0] kf);
        for (int i = 0; i < 3; i++)
            step_check($sformatf("%s_busy%0d", name, i), 4'd2, 0, 100, 1'b0, kf, 1'b0, 1'b0, 1'b1);
        step_check({name, "_done"}, 4'd2, 0, 100, 1'b0, kf, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n    = 1'b1;
        state    = 4'd0;
        player_x = 9'd0;
        player_y = 9'd0;
        act      = 1'b0;

        // Full stage walk: in-order pickups, ignored acts, cooldown timing, door.
        add_vec(4'd2,   0, 100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2,  70,  40, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        add_vec(4'd2,  70,  40, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 240, 210, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 150,   5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 240,  40, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240,  40, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 240, 210, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        add_vec(4'd2, 240, 210, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240, 210, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240, 210, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
        add_vec(4'd2, 240, 210, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 160,  20, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 175,   5, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 144,   5, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 150,   5, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        add_vec(4'd2, 150,   5, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 174,  19, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        add_vec(4'd0, 150,   5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset asserted between edges must clear outputs without a clock.
        #1 rst_n = 1'b0;
        #1 check_output("reset_async", 2'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].st, int'(vecs[i].x), int'(vecs[i].y), vecs[i].a);
            check_output($sformatf("vec%0d", i), vecs[i].kf, vecs[i].pp, vecs[i].sc, vecs[i].bz);
        end

        // Key1 hit-box edges: high bounds exclusive, low bounds inclusive.
        step_check("reenter",   4'd2,  0, 100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("edge_x85",  4'd2, 85,  40, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("edge_x64",  4'd2, 64,  40, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("edge_y55",  4'd2, 70,  55, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("edge_y34",  4'd2, 70,  34, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("edge_hit",  4'd2, 65,  54, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a cooldown; no pulse once it is released.
        rst_n = 1'b0;
        #1 check_output("reset_midcool", 2'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step_check("post_reset",  4'd2,  0, 100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Abort with a same-cycle act on the current key.
        step_check("k1", 4'd2, 70, 40, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        cooldown_tail("k1", 2'd1);
        step_check("k2", 4'd2, 240, 40, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
        cooldown_tail("k2", 2'd2);
        step_check("abort",       4'd8, 240, 210, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("restart",     4'd2,   0, 100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("restart_k2",  4'd2, 240,  40, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("restart_k1",  4'd2,  70,  40, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        step_check("abort_cool",  4'd8,  70,  40, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step_check("idle_hold",   4'd8,  70,  40, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
